game_flow_fsm: RTL and testbench
================================

Name: game_flow_fsm

Overview:
- Parametrised game-flow controller: the successor to the fixed 3-item menu FSM.
- Drives an N-item menu with cursor wrap, a pre-game countdown, the live game, and a timed scoreboard screen.
- Reacts only to new key presses (edge-detected keycodes), not held keys.
- Sits between the USB keyboard keycode path and the scoreboard, renderer and player/AI logic.

Parameters:
- NUM_ITEMS, 2, number of selectable menu items (2..16).
- COUNT_SECS, 3, pre-game countdown length in seconds (1..15).
- SCORE_HOLD_SECS, 10, seconds the scoreboard stays up before auto-return (1..255).
- MENU_WRAP, 1, 1 = cursor wraps at the ends of the list, 0 = cursor saturates.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- SecTick  in  1  one-cycle pulse once per second, from the scoreboard timer.
- TimeOver  in  1  game timer expired; level, sampled only in GAMEON.
- Inputs  in  8  current USB keycode; 0x00 means no key.
- MenuActive  out  1  menu screen visible (IDLE or MENU).
- MenuSel  out  SEL_W  cursor index, where SEL_W = max(1, clog2(NUM_ITEMS)).
- CursorOn  out  1  cursor highlight visible (MENU only).
- Mode  out  SEL_W  item latched on ENTER; held until the next ENTER selection.
- CountVal  out  4  remaining countdown seconds; 0 outside COUNTDOWN.
- GameStart  out  1  gameplay enabled (GAMEON only).
- GameOver  out  1  scoreboard screen (SCOREBOARD only).
- WipeScore  out  1  clear scores (IDLE, MENU, COUNTDOWN).

Behaviour:
- Key decoding:
  - Keycodes: W=0x1A, A=0x04, S=0x16, D=0x07, ENTER=0x28, ESC=0x29.
  - prev_key register, reset value 0x00, updated every cycle.
  - A press event is `Inputs != prev_key && Inputs != 0`.
  - Only press events cause transitions; a held key acts once.
- Reset (asynchronous): state=IDLE, MenuSel=0, Mode=0, count=0, hold=0, prev_key=0.
- All outputs are registered or decoded from registered state. Outputs change one cycle after the triggering event.
- IDLE:
  - MenuActive=1, CursorOn=0, WipeScore=1.
  - Any press of W/A/S/D/ENTER -> MENU with MenuSel=0. Other keys are ignored.
- MENU:
  - MenuActive=1, CursorOn=1, WipeScore=1.
  - S press: MenuSel+1. At NUM_ITEMS-1 it goes to 0 if MENU_WRAP=1, else holds.
  - W press: MenuSel-1. At 0 it goes to NUM_ITEMS-1 if MENU_WRAP=1, else holds.
  - A/D presses: no effect.
  - ENTER press: Mode<=MenuSel, count<=COUNT_SECS, -> COUNTDOWN.
  - ESC press: -> IDLE, MenuSel unchanged.
- COUNTDOWN:
  - WipeScore=1, CountVal=count.
  - On SecTick, count decrements. A SecTick while count==1 -> GAMEON (count<=0).
  - Keys are ignored.
- GAMEON:
  - GameStart=1.
  - TimeOver=1 -> SCOREBOARD with hold<=SCORE_HOLD_SECS. TimeOver has priority over any key in the same cycle.
- SCOREBOARD:
  - GameOver=1.
  - On SecTick, hold decrements.
  - ENTER press -> MENU with MenuSel=Mode (cursor returns to the last item played).
  - hold reaching 0 -> IDLE.
  - ENTER and final SecTick in the same cycle: ENTER wins.
- Illegal state encoding -> IDLE on the next cycle (default branch).
- Mode is stable throughout COUNTDOWN, GAMEON and SCOREBOARD.

Optional Feature:
- Macro: GAME_FLOW_PAUSE_EN.
- When defined:
  - Adds state PAUSED and output port GamePaused (1 bit).
  - In GAMEON, an ESC press -> PAUSED: GameStart=0, GamePaused=1, scores preserved (WipeScore=0).
  - In PAUSED, an ESC press -> GAMEON.
  - In PAUSED, an ENTER press -> IDLE (abandon game; WipeScore asserts in IDLE as usual).
  - TimeOver is ignored while PAUSED; the scoreboard timer is gated by GameStart.
- When undefined: no PAUSED state, no GamePaused port, and ESC in GAMEON is ignored.

Decomposition:
- Package game_flow_pkg holds:
  - keycode localparams (KEY_W, KEY_A, KEY_S, KEY_D, KEY_ENTER, KEY_ESC);
  - the state enum typedef (3-bit);
  - the helper function sel_width(n).
- One sub-module, key_press_detect:
  - owns the prev_key register;
  - outputs one-cycle pulses press_up, press_down, press_enter, press_esc, press_any.

Test Plan:
- Reset mid-GAMEON: assert Reset asynchronously between clock edges -> immediately state IDLE, GameStart=0, MenuSel=0, Mode=0, WipeScore=1.
- NUM_ITEMS=3, MENU_WRAP=1: from IDLE press D -> MENU, MenuSel=0. Then press W -> MenuSel=2; press S -> MenuSel=0.
- MENU_WRAP=0: press W at 0 -> stays 0. Hold S for 50 cycles -> MenuSel increments exactly once.
- Select item 1 and press ENTER with COUNT_SECS=3:
  - -> CountVal reads 3,2,1 across SecTicks;
  - GameStart=1 one cycle after the third SecTick;
  - Mode=1.
- In GAMEON, drive TimeOver=1 and ENTER together -> SCOREBOARD (not MENU). Then:
  - with SCORE_HOLD_SECS=2, two SecTicks -> IDLE;
  - on a repeat run, ENTER on the second SecTick -> MENU with MenuSel=Mode.
- With GAME_FLOW_PAUSE_EN defined:
  - ESC in GAMEON -> GamePaused=1, GameStart=0;
  - TimeOver is ignored while PAUSED;
  - ESC -> GAMEON;
  - pause again, then ENTER -> IDLE.

Source files
------------

// File: rtl/game_flow_pkg.sv
// Shared definitions for game_flow_fsm: USB keycodes, state encoding and select-width helper.
// ST_PAUSED exists only when GAME_FLOW_PAUSE_EN is defined.
package game_flow_pkg;

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MENU       = 3'd1,
        ST_COUNTDOWN  = 3'd2,
        ST_GAMEON     = 3'd3,
`ifdef GAME_FLOW_PAUSE_EN
        ST_PAUSED     = 3'd5,
`endif
        ST_SCOREBOARD = 3'd4
    } state_e;

    // A one-item-wide select still needs one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/game_flow_fsm_if.sv
// Game-flow signal bundle: keycode/timer inputs towards the controller, screen/game controls back.
// GamePaused is present only when GAME_FLOW_PAUSE_EN is defined.
interface game_flow_fsm_if #(
    parameter int SEL_W = 1
);
    logic             SecTick;
    logic             TimeOver;
    logic [7:0]       Inputs;
    logic             MenuActive;
    logic [SEL_W-1:0] MenuSel;
    logic             CursorOn;
    logic [SEL_W-1:0] Mode;
    logic [3:0]       CountVal;
    logic             GameStart;
    logic             GameOver;
    logic             WipeScore;
`ifdef GAME_FLOW_PAUSE_EN
    logic             GamePaused;
`endif

    modport master (
        output SecTick, TimeOver, Inputs,
`ifdef GAME_FLOW_PAUSE_EN
        input  GamePaused,
`endif
        input  MenuActive, MenuSel, CursorOn, Mode, CountVal, GameStart, GameOver, WipeScore
    );

    modport slave (
        input  SecTick, TimeOver, Inputs,
`ifdef GAME_FLOW_PAUSE_EN
        output GamePaused,
`endif
        output MenuActive, MenuSel, CursorOn, Mode, CountVal, GameStart, GameOver, WipeScore
    );

endinterface

// File: rtl/key_press_detect.sv
// Turns the raw USB keycode into one-cycle press pulses; a held key produces a single pulse.
module key_press_detect
    import game_flow_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] i_key,
    output logic       press_up,
    output logic       press_down,
    output logic       press_enter,
    output logic       press_esc,
    output logic       press_any
);

    logic [7:0] r_prev_key;
    logic       w_press;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_prev_key <= 8'h00;
        else       r_prev_key <= i_key;
    end

    assign w_press     = (i_key != r_prev_key) && (i_key != 8'h00);
    assign press_up    = w_press && (i_key == KEY_W);
    assign press_down  = w_press && (i_key == KEY_S);
    assign press_enter = w_press && (i_key == KEY_ENTER);
    assign press_esc   = w_press && (i_key == KEY_ESC);
    // Navigation-class keys only: these are the ones that wake the menu from IDLE.
    assign press_any   = w_press && (i_key inside {KEY_W, KEY_A, KEY_S, KEY_D, KEY_ENTER});

endmodule

// File: rtl/game_flow_fsm.sv
// Game-flow controller: N-item menu, pre-game countdown, live game and timed scoreboard.
// Define GAME_FLOW_PAUSE_EN to add the PAUSED state and the GamePaused output.
module game_flow_fsm
    import game_flow_pkg::*;
#(
    parameter int NUM_ITEMS       = 2,
    parameter int COUNT_SECS      = 3,
    parameter int SCORE_HOLD_SECS = 10,
    parameter int MENU_WRAP       = 1
)(
    input  logic          Clk,
    input  logic          Reset,
    game_flow_fsm_if.slave bus
);

    localparam int               SEL_W      = sel_width(NUM_ITEMS);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_ITEMS - 1);
    localparam logic [3:0]       COUNT_INIT = 4'(COUNT_SECS);
    localparam logic [7:0]       HOLD_INIT  = 8'(SCORE_HOLD_SECS);

    state_e           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [SEL_W-1:0] r_mode, w_mode_nxt;
    logic [3:0]       r_count, w_count_nxt;
    logic [7:0]       r_hold, w_hold_nxt;
    logic             w_press_up, w_press_down, w_press_enter, w_press_esc, w_press_any;

    key_press_detect u_keys (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_key       (bus.Inputs),
        .press_up    (w_press_up),
        .press_down  (w_press_down),
        .press_enter (w_press_enter),
        .press_esc   (w_press_esc),
        .press_any   (w_press_any)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_mode  <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_mode  <= w_mode_nxt;
            r_count <= w_count_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // NOTE: every next-state value is defaulted first, so no path through the case infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_mode_nxt  = r_mode;
        w_count_nxt = r_count;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_press_any) begin
                    w_state_nxt = ST_MENU;
                    w_sel_nxt   = '0;
                end
            end
            ST_MENU: begin
                if (w_press_enter) begin
                    w_mode_nxt  = r_sel;
                    w_count_nxt = COUNT_INIT;
                    w_state_nxt = ST_COUNTDOWN;
                end else if (w_press_esc) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_press_down) begin
                    if (r_sel != LAST_SEL)   w_sel_nxt = r_sel + 1'b1;
                    else if (MENU_WRAP != 0) w_sel_nxt = '0;
                end else if (w_press_up) begin
                    if (r_sel != '0)         w_sel_nxt = r_sel - 1'b1;
                    else if (MENU_WRAP != 0) w_sel_nxt = LAST_SEL;
                end
            end
            ST_COUNTDOWN: begin
                if (bus.SecTick) begin
                    if (r_count <= 4'd1) begin
                        w_count_nxt = 4'd0;
                        w_state_nxt = ST_GAMEON;
                    end else begin
                        w_count_nxt = r_count - 4'd1;
                    end
                end
            end
            ST_GAMEON: begin
                if (bus.TimeOver) begin
                    w_hold_nxt  = HOLD_INIT;
                    w_state_nxt = ST_SCOREBOARD;
`ifdef GAME_FLOW_PAUSE_EN
                end else if (w_press_esc) begin
                    w_state_nxt = ST_PAUSED;
                end
`else
                end
`endif
            end
`ifdef GAME_FLOW_PAUSE_EN
            ST_PAUSED: begin
                if (w_press_esc)        w_state_nxt = ST_GAMEON;
                else if (w_press_enter) w_state_nxt = ST_IDLE;
            end
`endif
            ST_SCOREBOARD: begin
                // ENTER beats the final SecTick so the player can go straight back to the menu.
                if (w_press_enter) begin
                    w_sel_nxt   = r_mode;
                    w_state_nxt = ST_MENU;
                end else if (bus.SecTick) begin
                    if (r_hold <= 8'd1) begin
                        w_hold_nxt  = 8'd0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_hold_nxt  = r_hold - 8'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.MenuActive = (r_state == ST_IDLE) || (r_state == ST_MENU);
    assign bus.CursorOn   = (r_state == ST_MENU);
    assign bus.MenuSel    = r_sel;
    assign bus.Mode       = r_mode;
    assign bus.CountVal   = (r_state == ST_COUNTDOWN) ? r_count : 4'd0;
    assign bus.GameStart  = (r_state == ST_GAMEON);
    assign bus.GameOver   = (r_state == ST_SCOREBOARD);
    assign bus.WipeScore  = (r_state == ST_IDLE) || (r_state == ST_MENU) || (r_state == ST_COUNTDOWN);
`ifdef GAME_FLOW_PAUSE_EN
    assign bus.GamePaused = (r_state == ST_PAUSED);
`endif

endmodule

// File: tb/tb_game_flow_fsm.sv
// Bench for game_flow_fsm: two configurations share one stimulus stream and are checked
// against a behavioural screen model; GAME_FLOW_PAUSE_EN adds the pause scenario.
module tb_game_flow_fsm;
    import game_flow_pkg::*;

    typedef enum {S_IDLE, S_MENU, S_COUNT, S_GAME, S_SCORE, S_PAUSE} scr_e;

    typedef struct {
        scr_e       scr;
        int         sel;
        int         mode;
        int         count;
        int         hold;
        logic [7:0] prev;
        int         n;
        int         cs;
        int         hs;
        bit         wrap;
    } model_t;

    typedef struct {
        logic [31:0] ma, sel, cur, mode, cv, gs, go, wipe, paused;
    } outs_t;

    typedef struct {
        logic [7:0] key;
        logic       tick;
        logic       to;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] key = 8'h00;
    logic       sec_tick = 1'b0;
    logic       time_over = 1'b0;
    int         checks = 0;
    int         errors = 0;
    model_t     mdl_a, mdl_b;
    vec_t       tbl[$];

    always #5 clk = ~clk;

    game_flow_fsm_if #(.SEL_W(2)) if_a ();
    game_flow_fsm_if #(.SEL_W(3)) if_b ();

    assign if_a.SecTick  = sec_tick;
    assign if_a.TimeOver = time_over;
    assign if_a.Inputs   = key;
    assign if_b.SecTick  = sec_tick;
    assign if_b.TimeOver = time_over;
    assign if_b.Inputs   = key;

    game_flow_fsm #(.NUM_ITEMS(3), .COUNT_SECS(3), .SCORE_HOLD_SECS(2), .MENU_WRAP(1)) u_dut_a (
        .Clk(clk), .Reset(rst), .bus(if_a.slave));
    game_flow_fsm #(.NUM_ITEMS(5), .COUNT_SECS(2), .SCORE_HOLD_SECS(3), .MENU_WRAP(0)) u_dut_b (
        .Clk(clk), .Reset(rst), .bus(if_b.slave));

    function automatic model_t model_init(input int n, input int cs, input int hs, input bit wrap);
        model_t m;
        m.scr = S_IDLE; m.sel = 0; m.mode = 0; m.count = 0; m.hold = 0; m.prev = 8'h00;
        m.n = n; m.cs = cs; m.hs = hs; m.wrap = wrap;
        return m;
    endfunction

    // Screen-level rules: a press is a new non-zero keycode; one step per clock.
    function automatic model_t model_step(input model_t m, input logic [7:0] k, input logic t, input logic o);
        model_t r;
        logic   press;
        r = m;
        r.prev = k;
        press = (k != m.prev) && (k != 8'h00);
        case (m.scr)
            S_IDLE: if (press && (k inside {KEY_W, KEY_A, KEY_S, KEY_D, KEY_ENTER})) begin
                r.scr = S_MENU; r.sel = 0;
            end
            S_MENU: if (press) begin
                if (k == KEY_W)
                    r.sel = m.wrap ? (m.sel + m.n - 1) % m.n : ((m.sel > 0) ? m.sel - 1 : 0);
                else if (k == KEY_S)
                    r.sel = m.wrap ? (m.sel + 1) % m.n : ((m.sel + 1 < m.n) ? m.sel + 1 : m.sel);
                else if (k == KEY_ENTER) begin
                    r.mode = m.sel; r.count = m.cs; r.scr = S_COUNT;
                end else if (k == KEY_ESC)
                    r.scr = S_IDLE;
            end
            S_COUNT: if (t) begin
                r.count = m.count - 1;
                if (r.count == 0) r.scr = S_GAME;
            end
            S_GAME: begin
                if (o) begin
                    r.scr = S_SCORE; r.hold = m.hs;
                end
`ifdef GAME_FLOW_PAUSE_EN
                else if (press && k == KEY_ESC) r.scr = S_PAUSE;
`endif
            end
            S_PAUSE: begin
                if (press && k == KEY_ESC)        r.scr = S_GAME;
                else if (press && k == KEY_ENTER) r.scr = S_IDLE;
            end
            S_SCORE: begin
                if (press && k == KEY_ENTER) begin
                    r.scr = S_MENU; r.sel = m.mode;
                end else if (t) begin
                    r.hold = m.hold - 1;
                    if (r.hold == 0) r.scr = S_IDLE;
                end
            end
            default: r.scr = S_IDLE;
        endcase
        return r;
    endfunction

    function automatic outs_t model_outs(input model_t m);
        outs_t o;
        o.ma     = 32'((m.scr == S_IDLE) || (m.scr == S_MENU));
        o.sel    = 32'(m.sel);
        o.cur    = 32'(m.scr == S_MENU);
        o.mode   = 32'(m.mode);
        o.cv     = (m.scr == S_COUNT) ? 32'(m.count) : 32'd0;
        o.gs     = 32'(m.scr == S_GAME);
        o.go     = 32'(m.scr == S_SCORE);
        o.wipe   = 32'((m.scr == S_IDLE) || (m.scr == S_MENU) || (m.scr == S_COUNT));
        o.paused = 32'(m.scr == S_PAUSE);
        return o;
    endfunction

    function automatic outs_t mk(input int ma, input int sel, input int cur, input int mode,
                                 input int cv, input int gs, input int go, input int wipe);
        outs_t o;
        o.ma = ma; o.sel = sel; o.cur = cur; o.mode = mode;
        o.cv = cv; o.gs = gs; o.go = go; o.wipe = wipe; o.paused = 0;
        return o;
    endfunction

    function automatic outs_t act_a();
        outs_t o;
        o.ma = 32'(if_a.MenuActive); o.sel = 32'(if_a.MenuSel); o.cur = 32'(if_a.CursorOn);
        o.mode = 32'(if_a.Mode); o.cv = 32'(if_a.CountVal); o.gs = 32'(if_a.GameStart);
        o.go = 32'(if_a.GameOver); o.wipe = 32'(if_a.WipeScore);
`ifdef GAME_FLOW_PAUSE_EN
        o.paused = 32'(if_a.GamePaused);
`else
        o.paused = 32'd0;
`endif
        return o;
    endfunction

    function automatic outs_t act_b();
        outs_t o;
        o.ma = 32'(if_b.MenuActive); o.sel = 32'(if_b.MenuSel); o.cur = 32'(if_b.CursorOn);
        o.mode = 32'(if_b.Mode); o.cv = 32'(if_b.CountVal); o.gs = 32'(if_b.GameStart);
        o.go = 32'(if_b.GameOver); o.wipe = 32'(if_b.WipeScore);
`ifdef GAME_FLOW_PAUSE_EN
        o.paused = 32'(if_b.GamePaused);
`else
        o.paused = 32'd0;
`endif
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input outs_t act, input outs_t exp);
        check({tag, ".menu_active"}, act.ma, exp.ma);
        check({tag, ".menu_sel"}, act.sel, exp.sel);
        check({tag, ".cursor_on"}, act.cur, exp.cur);
        check({tag, ".mode"}, act.mode, exp.mode);
        check({tag, ".count_val"}, act.cv, exp.cv);
        check({tag, ".game_start"}, act.gs, exp.gs);
        check({tag, ".game_over"}, act.go, exp.go);
        check({tag, ".wipe_score"}, act.wipe, exp.wipe);
        check({tag, ".game_paused"}, act.paused, exp.paused);
    endtask

    // Drive one cycle of inputs, advance both models on the edge, compare 1 ns later.
    task automatic step(input logic [7:0] k, input logic t, input logic o);
        key = k; sec_tick = t; time_over = o;
        @(posedge clk);
        mdl_a = model_step(mdl_a, k, t, o);
        mdl_b = model_step(mdl_b, k, t, o);
        #1;
        cmp("a_model", act_a(), model_outs(mdl_a));
        cmp("b_model", act_b(), model_outs(mdl_b));
    endtask

    task automatic add_vec(input logic [7:0] k, input logic t, input logic o, input outs_t e);
        vec_t v;
        v.key = k; v.tick = t; v.to = o; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach its summary line");
        $fatal(1, "timeout");
    end

    initial begin
        int         r;
        logic [7:0] rk;

        mdl_a = model_init(3, 3, 2, 1'b1);
        mdl_b = model_init(5, 2, 3, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp("a_reset", act_a(), mk(1, 0, 0, 0, 0, 0, 0, 1));
        cmp("b_reset", act_b(), mk(1, 0, 0, 0, 0, 0, 0, 1));

        // DUT A: wrap on 3 items, select item 1, count 3-2-1, TimeOver+ENTER, two ticks back to IDLE.
        add_vec(KEY_D,     1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 0, 1));
        add_vec(8'h00,     1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 0, 1));
        add_vec(KEY_W,     1'b0, 1'b0, mk(1, 2, 1, 0, 0, 0, 0, 1));
        add_vec(8'h00,     1'b0, 1'b0, mk(1, 2, 1, 0, 0, 0, 0, 1));
        add_vec(KEY_S,     1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 0, 1));
        add_vec(8'h00,     1'b0, 1'b0, mk(1, 0, 1, 0, 0, 0, 0, 1));
        add_vec(KEY_S,     1'b0, 1'b0, mk(1, 1, 1, 0, 0, 0, 0, 1));
        add_vec(8'h00,     1'b0, 1'b0, mk(1, 1, 1, 0, 0, 0, 0, 1));
        add_vec(KEY_ENTER, 1'b0, 1'b0, mk(0, 1, 0, 1, 3, 0, 0, 1));
        add_vec(8'h00,     1'b1, 1'b0, mk(0, 1, 0, 1, 2, 0, 0, 1));
        add_vec(8'h00,     1'b0, 1'b0, mk(0, 1, 0, 1, 2, 0, 0, 1));
        add_vec(8'h00,     1'b1, 1'b0, mk(0, 1, 0, 1, 1, 0, 0, 1));
        add_vec(8'h00,     1'b1, 1'b0, mk(0, 1, 0, 1, 0, 1, 0, 0));
        add_vec(KEY_ENTER, 1'b0, 1'b1, mk(0, 1, 0, 1, 0, 0, 1, 0));
        add_vec(8'h00,     1'b1, 1'b0, mk(0, 1, 0, 1, 0, 0, 1, 0));
        add_vec(8'h00,     1'b1, 1'b0, mk(1, 1, 0, 1, 0, 0, 0, 1));
        foreach (tbl[i]) begin
            step(tbl[i].key, tbl[i].tick, tbl[i].to);
            cmp($sformatf("a_vec%0d", i), act_a(), tbl[i].exp);
        end

        // Repeat run choosing item 2; ENTER on the final SecTick must win over the timeout.
        step(KEY_D, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(KEY_W, 1'b0, 1'b0);
        step(KEY_ENTER, 1'b0, 1'b0);
        repeat (3) step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b1, 1'b0);
        step(KEY_ENTER, 1'b1, 1'b0);
        check("a_enter_beats_tick.cursor_on", 32'(if_a.CursorOn), 32'd1);
        check("a_enter_beats_tick.menu_sel", 32'(if_a.MenuSel), 32'd2);

        // Back into GAMEON with Mode=2, then an asynchronous reset between edges.
        step(8'h00, 1'b0, 1'b0);
        step(KEY_ENTER, 1'b0, 1'b0);
        repeat (3) step(8'h00, 1'b1, 1'b0);
        check("a_pre_reset.game_start", 32'(if_a.GameStart), 32'd1);
        #2 rst = 1'b1;
        #1;
        mdl_a = model_init(3, 3, 2, 1'b1);
        mdl_b = model_init(5, 2, 3, 1'b0);
        cmp("a_async_reset", act_a(), mk(1, 0, 0, 0, 0, 0, 0, 1));
        cmp("b_async_reset", act_b(), model_outs(mdl_b));
        @(posedge clk);
        #1 rst = 1'b0;

        // DUT B saturates: W at 0 stays 0; S held for 50 cycles moves exactly once.
        step(KEY_W, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(KEY_W, 1'b0, 1'b0);
        check("b_sat_low.menu_sel", 32'(if_b.MenuSel), 32'd0);
        check("a_wrap_low.menu_sel", 32'(if_a.MenuSel), 32'd2);
        step(8'h00, 1'b0, 1'b0);
        repeat (50) step(KEY_S, 1'b0, 1'b0);
        check("b_held_s.menu_sel", 32'(if_b.MenuSel), 32'd1);
        step(KEY_ESC, 1'b0, 1'b0);
        check("b_esc.menu_active", 32'(if_b.MenuActive), 32'd1);
        check("b_esc.cursor_on", 32'(if_b.CursorOn), 32'd0);

`ifdef GAME_FLOW_PAUSE_EN
        step(KEY_D, 1'b0, 1'b0);
        step(KEY_ENTER, 1'b0, 1'b0);
        repeat (3) step(8'h00, 1'b1, 1'b0);
        step(KEY_ESC, 1'b0, 1'b0);
        check("a_pause.game_paused", 32'(if_a.GamePaused), 32'd1);
        check("a_pause.game_start", 32'(if_a.GameStart), 32'd0);
        check("a_pause.wipe_score", 32'(if_a.WipeScore), 32'd0);
        step(8'h00, 1'b0, 1'b1);
        check("a_pause_timeover.game_paused", 32'(if_a.GamePaused), 32'd1);
        check("a_pause_timeover.game_over", 32'(if_a.GameOver), 32'd0);
        step(KEY_ESC, 1'b0, 1'b0);
        check("a_resume.game_start", 32'(if_a.GameStart), 32'd1);
        step(8'h00, 1'b0, 1'b0);
        step(KEY_ESC, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        step(KEY_ENTER, 1'b0, 1'b0);
        check("a_abandon.menu_active", 32'(if_a.MenuActive), 32'd1);
        check("a_abandon.wipe_score", 32'(if_a.WipeScore), 32'd1);
        check("a_abandon.game_paused", 32'(if_a.GamePaused), 32'd0);
`endif

        // Random keys (often held), ticks and timeouts against the screen model.
        rk = 8'h00;
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: rk = rk;
                3:       rk = 8'h00;
                4:       rk = KEY_W;
                5:       rk = KEY_S;
                6:       rk = KEY_ENTER;
                7:       rk = KEY_ESC;
                8:       rk = ($urandom_range(0, 1) != 0) ? KEY_A : KEY_D;
                default: rk = 8'($urandom);
            endcase
            step(rk, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
